// File: rtl/pc_redirect_ctrl_if.sv
// Redirect-controller bus: ID/EX hazard and fetch-side inputs, PC-force and flush outputs.
// master = pipeline side driving ID/resolve/I-cache status, slave = pc_redirect_ctrl.
interface pc_redirect_ctrl_if #(
    parameter int unsigned WORD_SIZE = 16
);
    logic                 id_valid;
    logic [WORD_SIZE-1:0] id_pc;
    logic                 real_pc_valid;
    logic [WORD_SIZE-1:0] real_pc;
    logic                 icache_busy;

    logic                 force_pc;
    logic [WORD_SIZE-1:0] force_pc_data;
    logic                 flush_if;
    logic                 flush_id;
    logic                 redirect_pending;
    logic                 drain_error;
    logic [15:0]          redirect_count;
    logic [15:0]          drain_cycles;

    modport master (
        output id_valid, id_pc, real_pc_valid, real_pc, icache_busy,
        input  force_pc, force_pc_data, flush_if, flush_id, redirect_pending,
               drain_error, redirect_count, drain_cycles
    );

    modport slave (
        input  id_valid, id_pc, real_pc_valid, real_pc, icache_busy,
        output force_pc, force_pc_data, flush_if, flush_id, redirect_pending,
               drain_error, redirect_count, drain_cycles
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Control-hazard recovery sequencer: defers the PC redirect until the I-cache is idle.
// Optional statistics counters are built when REDIRECT_STATS_EN is defined.
module pc_redirect_ctrl #(
    parameter int unsigned WORD_SIZE     = 16,
    parameter int unsigned DRAIN_TIMEOUT = 15
) (
    input logic               clk,
    input logic               reset,
    pc_redirect_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(DRAIN_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WORD_SIZE-1:0] r_tgt;
    logic [CNT_W-1:0]     r_drain_cnt;
    logic                 r_force_pc;
    logic                 r_flush;
    logic                 r_pending;
    logic                 r_drain_error;

    logic                 w_mispredict;
    logic                 w_timeout;

    assign w_mispredict = (r_state == S_IDLE) && bus.id_valid && bus.real_pc_valid &&
                          (bus.id_pc != bus.real_pc);
    // Counter holds completed DRAIN cycles; this cycle would be number cnt+1.
    assign w_timeout    = (r_drain_cnt + CNT_W'(1)) >= TIMEOUT;

    // Outputs are registered from the next state, so they track r_state exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_tgt         <= '0;
            r_drain_cnt   <= '0;
            r_force_pc    <= 1'b0;
            r_flush       <= 1'b0;
            r_pending     <= 1'b0;
            r_drain_error <= 1'b0;
        end else begin
            r_force_pc <= 1'b0;
            r_flush    <= 1'b0;
            r_pending  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_mispredict) begin
                        r_tgt       <= bus.real_pc;
                        r_drain_cnt <= '0;
                        r_flush     <= 1'b1;
                        r_pending   <= 1'b1;
                        if (bus.icache_busy) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_state    <= S_ISSUE;
                            r_force_pc <= 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + CNT_W'(1);
                    r_flush     <= 1'b1;
                    r_pending   <= 1'b1;
                    if (!bus.icache_busy || w_timeout) begin
                        r_state    <= S_ISSUE;
                        r_force_pc <= 1'b1;
                        if (bus.icache_busy) begin
                            r_drain_error <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.force_pc         = r_force_pc;
    assign bus.force_pc_data    = r_tgt;
    assign bus.flush_if         = r_flush;
    assign bus.flush_id         = r_flush;
    assign bus.redirect_pending = r_pending;
    assign bus.drain_error      = r_drain_error;

`ifdef REDIRECT_STATS_EN
    logic [15:0] r_redirect_count;
    logic [15:0] r_drain_cycles;

    // Saturating statistics, advanced at the end of each ISSUE / DRAIN cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_redirect_count <= '0;
            r_drain_cycles   <= '0;
        end else begin
            if ((r_state == S_ISSUE) && (r_redirect_count != 16'hFFFF)) begin
                r_redirect_count <= r_redirect_count + 16'd1;
            end
            if ((r_state == S_DRAIN) && (r_drain_cycles != 16'hFFFF)) begin
                r_drain_cycles <= r_drain_cycles + 16'd1;
            end
        end
    end

    assign bus.redirect_count = r_redirect_count;
    assign bus.drain_cycles   = r_drain_cycles;
`else
    assign bus.redirect_count = 16'd0;
    assign bus.drain_cycles   = 16'd0;
`endif

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Sequencing controller for control-hazard recovery in the pipelined CPU with naive cache. It compares the PC of the instruction in ID against the resolved next PC and detects a misprediction. It then schedules the PC redirect and the IF/ID flushes so that the redirect never lands while the instruction cache is mid-fetch. It sits between the fetch stage (PC register, I-cache port) and the ID/EX hazard logic, and replaces same-cycle combinational PC forcing with a registered, handshaked redirect.

## Interface
- WORD_SIZE, 16, width of PCs.
- DRAIN_TIMEOUT, 15, max cycles DRAIN may wait on I-cache before error; 1..255.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- id_valid  input  1  ID stage holds a real (non-bubble) instruction.
- id_pc  input  WORD_SIZE  PC of instruction in ID.
- real_pc_valid  input  1  resolved next PC available this cycle.
- real_pc  input  WORD_SIZE  resolved next PC.
- icache_busy  input  1  I-cache has a fetch in flight.
- force_pc  output  1  load PC register with force_pc_data this cycle.
- force_pc_data  output  WORD_SIZE  redirect target.
- flush_if  output  1  squash the instruction fetched/returning in IF.
- flush_id  output  1  squash the instruction in ID.
- redirect_pending  output  1  controller is in DRAIN or ISSUE.
- drain_error  output  1  sticky; DRAIN exceeded DRAIN_TIMEOUT.
- redirect_count  output  16  redirects issued (statistics).
- drain_cycles  output  16  total cycles spent in DRAIN (statistics).

## Operation
- Mispredict = state IDLE & id_valid & real_pc_valid & (id_pc != real_pc).
- States: IDLE, DRAIN, ISSUE. Target register `tgt` captures real_pc on mispredict.
- IDLE: on mispredict with icache_busy=0 -> ISSUE; with icache_busy=1 -> DRAIN, drain counter cleared. Otherwise stay.
- DRAIN: flush_if=1, flush_id=1 every cycle. Drain counter increments each cycle. When icache_busy sampled 0 -> ISSUE. If drain counter reaches DRAIN_TIMEOUT with busy still 1 -> set drain_error, go to ISSUE anyway.
- ISSUE: force_pc=1, force_pc_data=tgt, flush_if=1, flush_id=1 for exactly one cycle -> IDLE.
- In DRAIN/ISSUE all new mispredict conditions are ignored (the ID instruction is wrong-path); tgt is not overwritten.
- force_pc_data equals tgt whenever force_pc=0 too (no X); it is cleared to 0 at reset.
- redirect_pending = (state != IDLE).
- PC compare is a full WORD_SIZE equality; there is no alignment masking.

## Timing
- Reset: state IDLE; tgt, force_pc_data, all flags, counters, and drain_error = 0. Reset asserted mid-DRAIN/ISSUE aborts with no redirect issued.
- All outputs are decoded from registered state/tgt only (Moore); there is no combinational input-to-output path.
- Latency: mispredict sampled at edge N with busy=0 -> force_pc high during cycle N+1 only.
- Busy case: mispredict at edge N with busy=1 -> DRAIN from N+1. If busy is first sampled 0 at edge M -> ISSUE during cycle M+1.
- Back-to-back: the earliest next accepted mispredict is sampled in the cycle after ISSUE (IDLE), giving force_pc at +2 cycles from the previous force.
- Timeout: with busy stuck, ISSUE follows DRAIN_TIMEOUT DRAIN cycles; drain_error stays 1 until reset.

## Configuration
- REDIRECT_STATS_EN defined:
  - redirect_count +1 on each ISSUE cycle.
  - drain_cycles +1 on each DRAIN cycle.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Not defined: both ports are tied to 0 and no counter flops are generated. All other behaviour is identical.

## Test plan
- Reset mid-DRAIN (busy=1, 3 cycles in DRAIN) -> all outputs 0 next cycle; state IDLE; no force_pc afterwards.
- Simple mispredict: id_pc=16'h0010, real_pc=16'h0040, valid, busy=0 -> one cycle later force_pc=1, force_pc_data=16'h0040, flush_if=flush_id=1 for one cycle. With id_pc==real_pc -> no outputs.
- Busy drain: same mismatch with busy=1 for 4 cycles -> flush_if/flush_id/redirect_pending high through DRAIN; force_pc pulses once the cycle after busy falls; drain_cycles=4 (stats on).
- Ignore during recovery: second mismatch real_pc=16'h0080 presented during DRAIN -> force_pc_data stays 16'h0040; only one force_pc pulse.
- Timeout: DRAIN_TIMEOUT=3, busy held high -> after 3 DRAIN cycles, force_pc pulses and drain_error=1 and stays 1.
- Stats macro off: repeat simple mispredict -> redirect_count=drain_cycles=0; on: 70000 redirects -> redirect_count=16'hFFFF.
